// File: rtl/btb_pkg.sv
// Shared constants, types and helpers for the branch target buffer.
package btb_pkg;

  localparam int unsigned PCW  = 30;
  localparam int unsigned IDXW = 3;
  localparam int unsigned SETS = 1 << IDXW;
  localparam int unsigned TAGW = PCW - IDXW;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_MAX = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WRITE  = 2'd2
  } btb_state_e;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [PCW-1:0]  target;
    logic [1:0]      ctr;
  } btb_entry_t;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btb_write_if.sv
// Update handshake between EX (master) and the BTB write side (slave).
interface btb_write_if;
  import btb_pkg::*;

  logic           upd_valid;
  logic           upd_ready;
  logic [PCW-1:0] upd_pc;
  logic [PCW-1:0] upd_target;
  logic           upd_taken;
  logic           upd_done;

  modport master (
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  upd_ready, upd_done
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output upd_ready, upd_done
  );

endinterface

// File: rtl/btb_victim_sel.sv
// Chooses the way to write: matching way first, then a free way, then LRU.
module btb_victim_sel (
  input  logic valid0,
  input  logic valid1,
  input  logic lru,
  input  logic hit0,
  input  logic hit1,
  output logic way_c,
  output logic hit_c
);

  // Hit on way0 wins over way1; on a miss prefer an invalid way.
  always_comb begin
    hit_c = hit0 | hit1;
    way_c = lru;
    if (hit0)        way_c = 1'b0;
    else if (hit1)   way_c = 1'b1;
    else if (!valid0) way_c = 1'b0;
    else if (!valid1) way_c = 1'b1;
  end

endmodule

// File: rtl/btb_write.sv
// Storage and update side of the 2-way, 8-set branch target buffer.
// Optional feature: define BTB_FLUSH_EN to add a synchronous flush input
// that clears all valid and LRU bits and aborts an update in flight.
module btb_write
  import btb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
`ifdef BTB_FLUSH_EN
  input  logic            flush,
`endif
  btb_write_if.slave      upd,
  input  logic [IDXW-1:0] rd_set,
  output logic            rd_valid0,
  output logic            rd_valid1,
  output logic [TAGW-1:0] rd_tag0,
  output logic [TAGW-1:0] rd_tag1,
  output logic [PCW-1:0]  rd_target0,
  output logic [PCW-1:0]  rd_target1,
  output logic [1:0]      rd_ctr0,
  output logic [1:0]      rd_ctr1
);

  btb_state_e state_q, state_d;

  btb_entry_t way0_q [SETS];
  btb_entry_t way1_q [SETS];
  logic [SETS-1:0] lru_q;

  logic [PCW-1:0]  req_pc_q;
  logic [PCW-1:0]  req_target_q;
  logic            req_taken_q;

  logic            dec_we_q;
  logic            dec_way_q;
  logic [IDXW-1:0] dec_set_q;
  btb_entry_t      dec_entry_q;

  logic            done_q;
  logic            flush_w;
  logic            accept;

  logic [IDXW-1:0] lk_set;
  logic [TAGW-1:0] lk_tag;
  btb_entry_t      lk_e0, lk_e1, lk_cur, lk_new;
  logic            lk_hit0, lk_hit1, lk_way, lk_hit, lk_we;

`ifdef BTB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign upd.upd_ready = (state_q == IDLE) & ~flush_w;
  assign upd.upd_done  = done_q;
  assign accept        = upd.upd_valid & upd.upd_ready;

  // Combinational IF read port; no bypass of a same-cycle write.
  assign rd_valid0  = way0_q[rd_set].valid;
  assign rd_valid1  = way1_q[rd_set].valid;
  assign rd_tag0    = way0_q[rd_set].tag;
  assign rd_tag1    = way1_q[rd_set].tag;
  assign rd_target0 = way0_q[rd_set].target;
  assign rd_target1 = way1_q[rd_set].target;
  assign rd_ctr0    = way0_q[rd_set].ctr;
  assign rd_ctr1    = way1_q[rd_set].ctr;

  // Lookup on the captured request: tag compare and way choice.
  assign lk_set  = req_pc_q[IDXW-1:0];
  assign lk_tag  = req_pc_q[PCW-1:IDXW];
  assign lk_e0   = way0_q[lk_set];
  assign lk_e1   = way1_q[lk_set];
  assign lk_hit0 = lk_e0.valid & (lk_e0.tag == lk_tag);
  assign lk_hit1 = lk_e1.valid & (lk_e1.tag == lk_tag);

  btb_victim_sel u_victim_sel (
    .valid0 (lk_e0.valid),
    .valid1 (lk_e1.valid),
    .lru    (lru_q[lk_set]),
    .hit0   (lk_hit0),
    .hit1   (lk_hit1),
    .way_c  (lk_way),
    .hit_c  (lk_hit)
  );

  assign lk_cur = lk_way ? lk_e1 : lk_e0;

  // New entry contents: train on a hit, allocate on a taken miss.
  always_comb begin
    lk_new = lk_cur;
    lk_we  = 1'b0;
    if (lk_hit) begin
      lk_we      = 1'b1;
      lk_new.ctr = ctr_next(lk_cur.ctr, req_taken_q);
      if (req_taken_q) lk_new.target = req_target_q;
    end else if (req_taken_q) begin
      lk_we         = 1'b1;
      lk_new.valid  = 1'b1;
      lk_new.tag    = lk_tag;
      lk_new.target = req_target_q;
      lk_new.ctr    = CTR_WT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_w) state_d = IDLE;
  end

  // Request capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q     <= '0;
      req_target_q <= '0;
      req_taken_q  <= 1'b0;
    end else if (accept) begin
      req_pc_q     <= upd.upd_pc;
      req_target_q <= upd.upd_target;
      req_taken_q  <= upd.upd_taken;
    end
  end

  // Register the lookup decision for the write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_we_q    <= 1'b0;
      dec_way_q   <= 1'b0;
      dec_set_q   <= '0;
      dec_entry_q <= '0;
    end else if (state_q == LOOKUP) begin
      dec_we_q    <= lk_we;
      dec_way_q   <= lk_way;
      dec_set_q   <= lk_set;
      dec_entry_q <= lk_new;
    end
  end

  // Completion pulse on the edge the array write commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_q == WRITE) & ~flush_w;
  end

  // Entry storage and LRU; flush wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SETS); i++) begin
        way0_q[i] <= '0;
        way1_q[i] <= '0;
      end
      lru_q <= '0;
    end else if (flush_w) begin
      for (int i = 0; i < int'(SETS); i++) begin
        way0_q[i].valid <= 1'b0;
        way1_q[i].valid <= 1'b0;
      end
      lru_q <= '0;
    end else if ((state_q == WRITE) && dec_we_q) begin
      if (dec_way_q) way1_q[dec_set_q] <= dec_entry_q;
      else           way0_q[dec_set_q] <= dec_entry_q;
      lru_q[dec_set_q] <= ~dec_way_q;
    end
  end

endmodule

// File: tb/tb_btb_write.sv
// Self-checking bench for btb_write against a behavioural BTB model.
module tb_btb_write;
  import btb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef BTB_FLUSH_EN
  logic flush = 1'b0;
`endif
  logic [2:0]  rd_set = '0;
  logic        rd_valid0, rd_valid1;
  logic [26:0] rd_tag0, rd_tag1;
  logic [29:0] rd_target0, rd_target1;
  logic [1:0]  rd_ctr0, rd_ctr1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain per-way arrays, LRU holds the way to evict next.
  logic        m_valid [2][8];
  logic [26:0] m_tag   [2][8];
  logic [29:0] m_tgt   [2][8];
  int          m_ctr   [2][8];
  int          m_lru   [8];

  btb_write_if bus();

  btb_write dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef BTB_FLUSH_EN
    .flush      (flush),
`endif
    .upd        (bus),
    .rd_set     (rd_set),
    .rd_valid0  (rd_valid0),
    .rd_valid1  (rd_valid1),
    .rd_tag0    (rd_tag0),
    .rd_tag1    (rd_tag1),
    .rd_target0 (rd_target0),
    .rd_target1 (rd_target1),
    .rd_ctr0    (rd_ctr0),
    .rd_ctr1    (rd_ctr1)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        m_valid[w][s] = 1'b0; m_tag[w][s] = '0; m_tgt[w][s] = '0; m_ctr[w][s] = 0;
      end
    for (int s = 0; s < 8; s++) m_lru[s] = 0;
  endfunction

  function automatic void model_update(input logic [29:0] pc, input logic [29:0] tgt, input logic tk);
    int s, w;
    logic [26:0] t;
    s = int'(pc % 30'd8);
    t = 27'(pc / 30'd8);
    w = -1;
    if (m_valid[0][s] && m_tag[0][s] == t) w = 0;
    else if (m_valid[1][s] && m_tag[1][s] == t) w = 1;
    if (w >= 0) begin
      if (tk) begin
        m_ctr[w][s] = (m_ctr[w][s] + 1 > 3) ? 3 : m_ctr[w][s] + 1;
        m_tgt[w][s] = tgt;
      end else begin
        m_ctr[w][s] = (m_ctr[w][s] - 1 < 0) ? 0 : m_ctr[w][s] - 1;
      end
      m_lru[s] = 1 - w;
    end else if (tk) begin
      if (!m_valid[0][s]) w = 0;
      else if (!m_valid[1][s]) w = 1;
      else w = m_lru[s];
      m_valid[w][s] = 1'b1; m_tag[w][s] = t; m_tgt[w][s] = tgt; m_ctr[w][s] = 2;
      m_lru[s] = 1 - w;
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    bus.upd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one request; lat = posedges from accept until upd_done seen, -1 on timeout.
  task automatic do_update(input logic [29:0] pc, input logic [29:0] tgt, input logic tk, output int lat);
    int guard;
    lat = -1;
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_target = tgt; bus.upd_taken = tk;
    guard = 0;
    while (bus.upd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (bus.upd_ready !== 1'b1) begin
      bus.upd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.upd_done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) model_update(pc, tgt, tk);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (bus.upd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.upd_ready); end
    n_checks++;
    if (bus.upd_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.upd_done); end
    for (int s = 0; s < 8; s++) begin
      @(negedge clk); rd_set = 3'(s); #1;
      n_checks++;
      if ({rd_valid0, rd_valid1, rd_ctr0, rd_ctr1, rd_tag0, rd_tag1, rd_target0, rd_target1} !== '0) begin
        n_fail++;
        $display("FAIL reset_set%0d got v=%b%b ctr=%0d/%0d tag=%h/%h tgt=%h/%h want all zero",
                 s, rd_valid0, rd_valid1, rd_ctr0, rd_ctr1, rd_tag0, rd_tag1, rd_target0, rd_target1);
      end
    end
  endtask

  task automatic test_alloc();
    int lat;
    do_update(30'h15, 30'h100, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL alloc_latency got %0d want 2", lat); end
    @(negedge clk); rd_set = 3'd5; #1;
    n_checks++;
    if (rd_valid0 !== 1'b1 || rd_tag0 !== 27'h2 || rd_target0 !== 30'h100 || rd_ctr0 !== 2'd2 || rd_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_entry got v0=%b tag0=%h tgt0=%h ctr0=%0d v1=%b want 1 2 100 2 0",
               rd_valid0, rd_tag0, rd_target0, rd_ctr0, rd_valid1);
    end
  endtask

  task automatic test_counter();
    logic       tk_seq  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] exp_seq [6] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    int lat;
    for (int k = 0; k < 6; k++) begin
      do_update(30'h15, 30'h100, tk_seq[k], lat);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL ctr_latency step%0d got %0d want 2", k, lat); end
      @(negedge clk); rd_set = 3'd5; #1;
      n_checks++;
      if (rd_ctr0 !== exp_seq[k] || rd_ctr0 !== 2'(m_ctr[0][5])) begin
        n_fail++;
        $display("FAIL ctr_step%0d got %0d want %0d", k, rd_ctr0, exp_seq[k]);
      end
    end
  endtask

  task automatic test_replace();
    int lat;
    apply_reset();
    do_update(30'h15, 30'h200, 1'b1, lat);
    do_update(30'h1D, 30'h300, 1'b1, lat);
    @(negedge clk); rd_set = 3'd5; #1;
    n_checks++;
    if (rd_tag0 !== 27'h2 || rd_tag1 !== 27'h3 || rd_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL repl_fill got tag0=%h tag1=%h v1=%b want 2 3 1", rd_tag0, rd_tag1, rd_valid1);
    end
    do_update(30'h15, 30'h208, 1'b1, lat);
    do_update(30'h25, 30'h400, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL repl_latency got %0d want 2", lat); end
    @(negedge clk); rd_set = 3'd5; #1;
    n_checks++;
    if (rd_tag0 !== 27'h2 || rd_target0 !== 30'h208 || rd_ctr0 !== 2'd3 ||
        rd_tag1 !== 27'h4 || rd_target1 !== 30'h400 || rd_ctr1 !== 2'd2) begin
      n_fail++;
      $display("FAIL repl_victim got w0=%h/%h/%0d w1=%h/%h/%0d want 2/208/3 4/400/2",
               rd_tag0, rd_target0, rd_ctr0, rd_tag1, rd_target1, rd_ctr1);
    end
  endtask

  task automatic test_nt_miss();
    int lat;
    do_update(30'h2F, 30'h77, 1'b1, lat);
    do_update(30'h3F, 30'h99, 1'b0, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL ntmiss_done got %0d want 2", lat); end
    @(negedge clk); rd_set = 3'd7; #1;
    n_checks++;
    if (rd_valid0 !== 1'b1 || rd_tag0 !== 27'h5 || rd_target0 !== 30'h77 || rd_ctr0 !== 2'd2 || rd_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ntmiss_set7 got v0=%b tag0=%h tgt0=%h ctr0=%0d v1=%b want 1 5 77 2 0",
               rd_valid0, rd_tag0, rd_target0, rd_ctr0, rd_valid1);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [29:0] pc, tgt;
    logic tk;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      pc  = 30'(($urandom_range(0, 4) << 3) | $urandom_range(0, 7));
      tgt = 30'($urandom);
      tk  = ($urandom_range(0, 2) != 0);
      do_update(pc, tgt, tk, lat);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL rand_latency op%0d got %0d want 2", n, lat); end
      for (int s = 0; s < 8; s++) begin
        @(negedge clk); rd_set = 3'(s); #1;
        n_checks++;
        if (rd_valid0 !== m_valid[0][s] || rd_valid1 !== m_valid[1][s] ||
            (m_valid[0][s] && (rd_tag0 !== m_tag[0][s] || rd_target0 !== m_tgt[0][s] || rd_ctr0 !== 2'(m_ctr[0][s]))) ||
            (m_valid[1][s] && (rd_tag1 !== m_tag[1][s] || rd_target1 !== m_tgt[1][s] || rd_ctr1 !== 2'(m_ctr[1][s])))) begin
          n_fail++;
          $display("FAIL rand_op%0d_set%0d got v=%b%b tag=%h/%h ctr=%0d/%0d want v=%b%b tag=%h/%h ctr=%0d/%0d",
                   n, s, rd_valid0, rd_valid1, rd_tag0, rd_tag1, rd_ctr0, rd_ctr1,
                   m_valid[0][s], m_valid[1][s], m_tag[0][s], m_tag[1][s], m_ctr[0][s], m_ctr[1][s]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] pcs [4] = '{30'h09, 30'h11, 30'h19, 30'h09};
    logic        tks [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = pcs[0]; bus.upd_target = 30'h1000; bus.upd_taken = tks[0];
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.upd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle req%0d got %b want 1", k, bus.upd_ready); end
      @(posedge clk);
      @(negedge clk);
      if (k < 3) begin
        bus.upd_pc = pcs[k+1]; bus.upd_target = 30'(30'h1000 + k + 1); bus.upd_taken = tks[k+1];
      end else begin
        bus.upd_valid = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        n_checks++;
        if (bus.upd_ready !== 1'b0 || bus.upd_done !== 1'b0) begin
          n_fail++; $display("FAIL b2b_busy req%0d cyc%0d got ready=%b done=%b want 0 0", k, c, bus.upd_ready, bus.upd_done);
        end
        @(negedge clk);
      end
      n_checks++;
      if (bus.upd_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done req%0d got %b want 1", k, bus.upd_done); end
      model_update(pcs[k], 30'(30'h1000 + k), tks[k]);
    end
    for (int s = 1; s <= 1; s++) begin
      @(negedge clk); rd_set = 3'(s); #1;
      n_checks++;
      if (rd_tag0 !== m_tag[0][s] || rd_tag1 !== m_tag[1][s] || rd_ctr0 !== 2'(m_ctr[0][s]) ||
          rd_ctr1 !== 2'(m_ctr[1][s]) || rd_valid1 !== m_valid[1][s]) begin
        n_fail++;
        $display("FAIL b2b_set%0d got tag=%h/%h ctr=%0d/%0d want tag=%h/%h ctr=%0d/%0d", s,
                 rd_tag0, rd_tag1, rd_ctr0, rd_ctr1, m_tag[0][s], m_tag[1][s], m_ctr[0][s], m_ctr[1][s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    apply_reset();
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = 30'h13; bus.upd_target = 30'h55; bus.upd_taken = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.upd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.upd_ready); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.upd_ready !== 1'b1 || bus.upd_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got ready=%b done=%b want 1 0", bus.upd_ready, bus.upd_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.upd_done === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rstmid_done got %0d pulses want 0", seen); end
    for (int s = 0; s < 8; s++) begin
      @(negedge clk); rd_set = 3'(s); #1;
      n_checks++;
      if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_set%0d got v=%b%b want 00", s, rd_valid0, rd_valid1);
      end
    end
  endtask

`ifdef BTB_FLUSH_EN
  task automatic test_flush();
    int lat, seen;
    apply_reset();
    do_update(30'h0A, 30'h321, 1'b1, lat);
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = 30'h12; bus.upd_target = 30'h444; bus.upd_taken = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus.upd_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", bus.upd_ready); end
    @(negedge clk);
    flush = 1'b0;
    for (int w = 0; w < 2; w++) for (int s = 0; s < 8; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < 8; s++) m_lru[s] = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.upd_done === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_done got %0d pulses want 0", seen); end
    @(negedge clk); rd_set = 3'd2; #1;
    n_checks++;
    if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || rd_tag0 !== 27'h1 || rd_target0 !== 30'h321) begin
      n_fail++; $display("FAIL flush_set2 got v=%b%b tag0=%h tgt0=%h want 00 1 321", rd_valid0, rd_valid1, rd_tag0, rd_target0);
    end
  endtask
`endif

  initial begin
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;
    model_reset();
    test_reset();
    test_alloc();
    test_counter();
    test_replace();
    test_nt_miss();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef BTB_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
